shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_pkg.sv | 13 +
 rtl/bit_counter.sv | 39 +++
 rtl/shift_sequencer.sv | 95 +++++++++
 tb/tb_shift_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding and the
// default frame length.
package shift_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/bit_counter.sv
// Frame bit counter: cleared when a frame is accepted, counts SHIFT cycles and
// saturates at WIDTH-1 so it can never wrap inside a frame.
module bit_counter
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == LAST);

endmodule

// File: rtl/shift_sequencer.sv
// Parallel-to-serial frame sequencer: captures a WIDTH-bit frame on start and
// shifts it out MSB- or LSB-first, followed by a one-cycle done pulse.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pdata,
  input  logic             msb_first,
  input  logic             abort,
  output logic             busy,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             msb_q, msb_d;
  logic             cnt_clear, cnt_en, cnt_tc;

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .tc_o     (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      msb_q   <= msb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    msb_d      = msb_q;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    busy       = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort is deliberately not looked at here: start alone decides.
        if (start) begin
          sreg_d    = pdata;
          msb_d     = msb_first;
          cnt_clear = 1'b1;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        busy       = 1'b1;
        sout_valid = 1'b1;
        sout       = msb_q ? sreg_q[WIDTH-1] : sreg_q[0];
        cnt_en     = 1'b1;
        sreg_d     = msb_q ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
        // Abort takes priority over the last bit so an aborted frame never signals done.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_tc) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus randomized
// frames compared against a bit-index model of the serial stream.
module tb_shift_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] pdata;
  logic         msb_first;
  logic         abort;
  logic         busy;
  logic         sout;
  logic         sout_valid;
  logic         done;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pdata      (pdata),
    .msb_first  (msb_first),
    .abort      (abort),
    .busy       (busy),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle; the bench then sits in the following cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: bit i of a frame is pdata[W-1-i] MSB-first, pdata[i] LSB-first.
  function automatic logic exp_bit(input logic [W-1:0] d, input logic m, input int i);
    return m ? d[W-1-i] : d[i];
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b1; pdata = 8'hFF; msb_first = 1'b1;
    step();
    step();
    checks++;
    if ({busy, sout_valid, sout, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs busy/valid/sout/done got %b want 0000",
               {busy, sout_valid, sout, done});
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    step();
    checks++;
    if ({busy, sout_valid, sout, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle busy/valid/sout/done got %b want 0000",
               {busy, sout_valid, sout, done});
    end
  endtask

  task automatic test_msb_frame();
    logic [7:0] want_bits;
    want_bits = 8'b10100101;
    pdata = 8'hA5; msb_first = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      checks++;
      if ({busy, sout_valid, sout, done} !== {2'b11, want_bits[W-1-i], 1'b0}) begin
        errors++;
        $display("FAIL msb_bit%0d busy/valid/sout/done got %b want %b", i,
                 {busy, sout_valid, sout, done}, {2'b11, want_bits[W-1-i], 1'b0});
      end
      step();
    end
    abort = 1'b1;  // abort in DONE must not cancel the pulse
    checks++;
    if ({busy, sout_valid, sout, done} !== 4'b1001) begin
      errors++;
      $display("FAIL msb_done busy/valid/sout/done got %b want 1001",
               {busy, sout_valid, sout, done});
    end
    step();
    abort = 1'b0;
    checks++;
    if ({busy, sout_valid, sout, done} !== 4'b0000) begin
      errors++;
      $display("FAIL msb_after_done busy/valid/sout/done got %b want 0000",
               {busy, sout_valid, sout, done});
    end
  endtask

  task automatic test_lsb_frame();
    pdata = 8'h01; msb_first = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == 2) begin
        pdata = 8'hFF; msb_first = 1'b1;
      end
      checks++;
      if ({busy, sout_valid, sout, done} !== {2'b11, (i == 0), 1'b0}) begin
        errors++;
        $display("FAIL lsb_bit%0d busy/valid/sout/done got %b want %b", i,
                 {busy, sout_valid, sout, done}, {2'b11, (i == 0), 1'b0});
      end
      step();
    end
    checks++;
    if ({busy, sout_valid, sout, done} !== 4'b1001) begin
      errors++;
      $display("FAIL lsb_done busy/valid/sout/done got %b want 1001",
               {busy, sout_valid, sout, done});
    end
    step();
  endtask

  task automatic test_back_to_back();
    pdata = 8'hFF; msb_first = 1'b1; start = 1'b1;
    step();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W; i++) begin
        checks++;
        if ({busy, sout_valid, sout, done} !== 4'b1110) begin
          errors++;
          $display("FAIL b2b_f%0d_bit%0d busy/valid/sout/done got %b want 1110", f, i,
                   {busy, sout_valid, sout, done});
        end
        step();
      end
      if (f == 1) start = 1'b0;
      checks++;
      if ({busy, sout_valid, sout, done} !== 4'b1001) begin
        errors++;
        $display("FAIL b2b_f%0d_done busy/valid/sout/done got %b want 1001", f,
                 {busy, sout_valid, sout, done});
      end
      step();
      checks++;
      if ({busy, sout_valid, done} !== 3'b000) begin
        errors++;
        $display("FAIL b2b_f%0d_idle_gap busy/valid/done got %b want 000", f,
                 {busy, sout_valid, done});
      end
      if (f == 0) step();
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] d1, d2;
    logic         m1, m2;
    d1 = W'($urandom); m1 = 1'($urandom);
    d2 = W'($urandom); m2 = 1'($urandom);
    pdata = d1; msb_first = m1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) abort = 1'b1;
      checks++;
      if ({busy, sout_valid, sout, done} !== {2'b11, exp_bit(d1, m1, i), 1'b0}) begin
        errors++;
        $display("FAIL abort_pre_bit%0d busy/valid/sout/done got %b want %b", i,
                 {busy, sout_valid, sout, done}, {2'b11, exp_bit(d1, m1, i), 1'b0});
      end
      step();
    end
    checks++;
    if ({busy, sout_valid, sout, done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle busy/valid/sout/done got %b want 0000",
               {busy, sout_valid, sout, done});
    end
    // abort still high in IDLE together with start: frame must still begin.
    pdata = d2; msb_first = m2; start = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < W; i++) begin
      checks++;
      if ({busy, sout_valid, sout, done} !== {2'b11, exp_bit(d2, m2, i), 1'b0}) begin
        errors++;
        $display("FAIL abort_restart_bit%0d busy/valid/sout/done got %b want %b", i,
                 {busy, sout_valid, sout, done}, {2'b11, exp_bit(d2, m2, i), 1'b0});
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart_done done got %b want 1", done);
    end
    step();
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] d;
    logic         m;
    d = W'($urandom); m = 1'($urandom);
    pdata = d; msb_first = m; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    step();
    checks++;
    if ({busy, sout_valid, sout, done} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_outputs busy/valid/sout/done got %b want 0000",
               {busy, sout_valid, sout, done});
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      step();
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL rst_mid_quiet%0d busy/done got %b want 00", i, {busy, done});
      end
    end
    d = W'($urandom); m = 1'($urandom);
    pdata = d; msb_first = m; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      checks++;
      if ({sout_valid, sout} !== {1'b1, exp_bit(d, m, i)}) begin
        errors++;
        $display("FAIL rst_mid_refill_bit%0d valid/sout got %b want %b", i,
                 {sout_valid, sout}, {1'b1, exp_bit(d, m, i)});
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_refill_done done got %b want 1", done);
    end
    step();
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    logic         m;
    int           abort_at;
    int           gap;
    for (int f = 0; f < 40; f++) begin
      d = W'($urandom); m = 1'($urandom);
      abort_at = ($urandom_range(2, 0) == 0) ? int'($urandom_range(W - 1, 0)) : -1;
      gap = int'($urandom_range(2, 0));
      for (int g = 0; g < gap; g++) begin
        abort = 1'($urandom);
        step();
      end
      pdata = d; msb_first = m; start = 1'b1; abort = 1'($urandom);
      step();
      abort = 1'b0;
      for (int i = 0; i < W; i++) begin
        start = 1'($urandom); pdata = W'($urandom); msb_first = 1'($urandom);
        checks++;
        if ({busy, sout_valid, sout, done} !== {2'b11, exp_bit(d, m, i), 1'b0}) begin
          errors++;
          $display("FAIL rnd_f%0d_bit%0d busy/valid/sout/done got %b want %b", f, i,
                   {busy, sout_valid, sout, done}, {2'b11, exp_bit(d, m, i), 1'b0});
        end
        if (i == abort_at) begin
          abort = 1'b1;
          break;
        end
        step();
      end
      if (abort_at >= 0) begin
        step();
        abort = 1'b0; start = 1'b0;
        checks++;
        if ({busy, sout_valid, sout, done} !== 4'b0000) begin
          errors++;
          $display("FAIL rnd_f%0d_aborted busy/valid/sout/done got %b want 0000", f,
                   {busy, sout_valid, sout, done});
        end
      end else begin
        start = 1'($urandom); abort = 1'($urandom);
        checks++;
        if ({busy, sout_valid, sout, done} !== 4'b1001) begin
          errors++;
          $display("FAIL rnd_f%0d_done busy/valid/sout/done got %b want 1001", f,
                   {busy, sout_valid, sout, done});
        end
        step();
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({busy, sout_valid, sout, done} !== 4'b0000) begin
          errors++;
          $display("FAIL rnd_f%0d_idle busy/valid/sout/done got %b want 0000", f,
                   {busy, sout_valid, sout, done});
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pdata = '0; msb_first = 1'b0;
    test_reset();
    test_msb_frame();
    test_lsb_frame();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
